// File: rtl/lmmi_cfg_bridge_pkg.sv
// Shared types and constants for the LMMI configuration bridge.
// Imported by the bridge, its port interface and its bench.
package lmmi_cfg_bridge_pkg;

  localparam int CH_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } state_e;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BAD_CH  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

endpackage

// File: rtl/lmmi_cfg_bridge_if.sv
// Command/response port plus the LMMI fan-out of the bridge.
// slave = bridge view, master = sequencer/slave-model view.
interface lmmi_cfg_bridge_if
  import lmmi_cfg_bridge_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 8,
  parameter int OFFSET_W = 5
) ();

  logic                       cmd_valid_i;
  logic                       cmd_ready_o;
  logic [CH_IDX_W-1:0]        cmd_ch_i;
  logic                       cmd_wr_i;
  logic [OFFSET_W-1:0]        cmd_offset_i;
  logic [DATA_W-1:0]          cmd_wdata_i;

  logic                       rsp_valid_o;
  logic                       rsp_ready_i;
  logic [DATA_W-1:0]          rsp_data_o;
  logic [1:0]                 rsp_status_o;
  logic [7:0]                 err_cnt_o;

  logic [NUM_CH-1:0]          lmmi_request_o;
  logic                       lmmi_wr_rdn_o;
  logic [OFFSET_W-1:0]        lmmi_offset_o;
  logic [DATA_W-1:0]          lmmi_wdata_o;
  logic [NUM_CH-1:0]          lmmi_ready_i;
  logic [NUM_CH*DATA_W-1:0]   lmmi_rdata_i;
  logic [NUM_CH-1:0]          lmmi_rdata_valid_i;

  modport slave (
    input  cmd_valid_i, cmd_ch_i, cmd_wr_i, cmd_offset_i, cmd_wdata_i, rsp_ready_i,
    input  lmmi_ready_i, lmmi_rdata_i, lmmi_rdata_valid_i,
    output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_status_o, err_cnt_o,
    output lmmi_request_o, lmmi_wr_rdn_o, lmmi_offset_o, lmmi_wdata_o
  );

  modport master (
    output cmd_valid_i, cmd_ch_i, cmd_wr_i, cmd_offset_i, cmd_wdata_i, rsp_ready_i,
    output lmmi_ready_i, lmmi_rdata_i, lmmi_rdata_valid_i,
    input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_status_o, err_cnt_o,
    input  lmmi_request_o, lmmi_wr_rdn_o, lmmi_offset_o, lmmi_wdata_o
  );

endinterface

// File: rtl/lmmi_cfg_bridge.sv
// One-at-a-time bridge from a valid/ready command port to NUM_CH LMMI slaves; LMMI_TIMEOUT_EN adds an abort timer.
// Request 1 cycle after accept, response 1 cycle after LMMI completion; response held until rsp_ready_i.
module lmmi_cfg_bridge
  import lmmi_cfg_bridge_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int DATA_W         = 8,
  parameter int OFFSET_W       = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic              sync_clk_i,
  input logic              sync_rst_i,
  lmmi_cfg_bridge_if.slave bus
);

  state_e                state_q, state_d;
  logic [CH_IDX_W-1:0]   ch_q, ch_d;
  logic                  wr_q, wr_d;
  logic [OFFSET_W-1:0]   offset_q, offset_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;

  logic [NUM_CH-1:0]     request_q, request_d;
  logic                  wr_rdn_q, wr_rdn_d;
  logic [OFFSET_W-1:0]   lmmi_offset_q, lmmi_offset_d;
  logic [DATA_W-1:0]     lmmi_wdata_q, lmmi_wdata_d;

  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_data_q, rsp_data_d;
  logic [1:0]            rsp_status_q, rsp_status_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  logic                  sel_ready;
  logic                  sel_rvalid;
  logic [DATA_W-1:0]     sel_rdata;
  logic                  tmo_hit;

`ifdef LMMI_TIMEOUT_EN
  localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0]           tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = (tmo_cnt_q >= TMO_LAST);
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  // Only the latched channel's ready/rdata_valid/rdata are ever looked at.
  always_comb begin
    sel_ready  = 1'b0;
    sel_rvalid = 1'b0;
    sel_rdata  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_q == CH_IDX_W'(k)) begin
        sel_ready  = bus.lmmi_ready_i[k];
        sel_rvalid = bus.lmmi_rdata_valid_i[k];
        sel_rdata  = bus.lmmi_rdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    wr_d          = wr_q;
    offset_d      = offset_q;
    wdata_d       = wdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_status_d  = rsp_status_q;
    err_cnt_d     = err_cnt_q;
    request_d     = '0;
    wr_rdn_d      = 1'b0;
    lmmi_offset_d = '0;
    lmmi_wdata_d  = '0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i) begin
          ch_d     = bus.cmd_ch_i;
          wr_d     = bus.cmd_wr_i;
          offset_d = bus.cmd_offset_i;
          wdata_d  = bus.cmd_wdata_i;
          if (int'(bus.cmd_ch_i) >= NUM_CH) begin
            state_d      = RESP;
            rsp_valid_d  = 1'b1;
            rsp_data_d   = '0;
            rsp_status_d = ST_BAD_CH;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // Completion is checked before the timer so a same-cycle finish reports OK.
        if (sel_ready) begin
          if (wr_q) begin
            state_d      = RESP;
            rsp_valid_d  = 1'b1;
            rsp_data_d   = '0;
            rsp_status_d = ST_OK;
          end else if (sel_rvalid) begin
            state_d      = RESP;
            rsp_valid_d  = 1'b1;
            rsp_data_d   = sel_rdata;
            rsp_status_d = ST_OK;
          end else begin
            state_d = WAIT_RD;
          end
        end else if (tmo_hit) begin
          state_d      = RESP;
          rsp_valid_d  = 1'b1;
          rsp_data_d   = '0;
          rsp_status_d = ST_TIMEOUT;
        end
      end
      WAIT_RD: begin
        if (sel_rvalid) begin
          state_d      = RESP;
          rsp_valid_d  = 1'b1;
          rsp_data_d   = sel_rdata;
          rsp_status_d = ST_OK;
        end else if (tmo_hit) begin
          state_d      = RESP;
          rsp_valid_d  = 1'b1;
          rsp_data_d   = '0;
          rsp_status_d = ST_TIMEOUT;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          state_d      = IDLE;
          rsp_valid_d  = 1'b0;
          rsp_data_d   = '0;
          rsp_status_d = ST_OK;
        end
      end
      default: state_d = IDLE;
    endcase

    // LMMI outputs are registered off the next state so they line up with REQ.
    if (state_d == REQ) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_d == CH_IDX_W'(k)) request_d[k] = 1'b1;
      end
      wr_rdn_d      = wr_d;
      lmmi_offset_d = offset_d;
      lmmi_wdata_d  = wdata_d;
    end

    if ((state_d == RESP) && (state_q != RESP) && (rsp_status_d != ST_OK) &&
        (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

`ifdef LMMI_TIMEOUT_EN
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == IDLE) begin
      tmo_cnt_d = '0;
    end else if ((state_q == REQ) || (state_q == WAIT_RD)) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end
`endif

  always_ff @(posedge sync_clk_i) begin
    if (sync_rst_i) begin
      state_q       <= IDLE;
      ch_q          <= '0;
      wr_q          <= 1'b0;
      offset_q      <= '0;
      wdata_q       <= '0;
      request_q     <= '0;
      wr_rdn_q      <= 1'b0;
      lmmi_offset_q <= '0;
      lmmi_wdata_q  <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_status_q  <= ST_OK;
      err_cnt_q     <= '0;
`ifdef LMMI_TIMEOUT_EN
      tmo_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      wr_q          <= wr_d;
      offset_q      <= offset_d;
      wdata_q       <= wdata_d;
      request_q     <= request_d;
      wr_rdn_q      <= wr_rdn_d;
      lmmi_offset_q <= lmmi_offset_d;
      lmmi_wdata_q  <= lmmi_wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_status_q  <= rsp_status_d;
      err_cnt_q     <= err_cnt_d;
`ifdef LMMI_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
`endif
    end
  end

  assign bus.cmd_ready_o    = (state_q == IDLE) && !sync_rst_i;
  assign bus.rsp_valid_o    = rsp_valid_q;
  assign bus.rsp_data_o     = rsp_data_q;
  assign bus.rsp_status_o   = rsp_status_q;
  assign bus.err_cnt_o      = err_cnt_q;
  assign bus.lmmi_request_o = request_q;
  assign bus.lmmi_wr_rdn_o  = wr_rdn_q;
  assign bus.lmmi_offset_o  = lmmi_offset_q;
  assign bus.lmmi_wdata_o   = lmmi_wdata_q;

endmodule

// File: tb/tb_lmmi_cfg_bridge.sv
// Directed bench for lmmi_cfg_bridge: responses checked by a queue-based monitor, LMMI timing checked inline.
// Covers the timeout path when built with LMMI_TIMEOUT_EN.
module tb_lmmi_cfg_bridge;
  import lmmi_cfg_bridge_pkg::*;

  localparam int NUM_CH   = 4;
  localparam int DATA_W   = 8;
  localparam int OFFSET_W = 5;
  localparam int TMO      = 16;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] status;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lmmi_cfg_bridge_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .OFFSET_W(OFFSET_W)) bus ();

  lmmi_cfg_bridge #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .OFFSET_W(OFFSET_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .sync_clk_i(clk),
    .sync_rst_i(rst),
    .bus       (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  rsp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one time unit after the accepting edge.
  task automatic drive_cmd(input logic [3:0] ch, input logic wr, input logic [4:0] off,
                           input logic [7:0] wd);
    bit got = 1'b0;
    bus.cmd_valid_i  = 1'b1;
    bus.cmd_ch_i     = ch;
    bus.cmd_wr_i     = wr;
    bus.cmd_offset_i = off;
    bus.cmd_wdata_i  = wd;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = bus.cmd_ready_o;
    end
    check("cmd_accept", 32'(got), 32'd1);
    tick();
    bus.cmd_valid_i = 1'b0;
  endtask

  // Scoreboard monitor: every response handshake pops one expected entry.
  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.rsp_valid_o && bus.rsp_ready_i) begin
        check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rsp_data", 32'(bus.rsp_data_o), 32'(e.data));
          check("rsp_status", 32'(bus.rsp_status_o), 32'(e.status));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int  cnt;
    int  cyc;
    bit  seen;
    bus.cmd_valid_i        = 1'b0;
    bus.cmd_ch_i           = '0;
    bus.cmd_wr_i           = 1'b0;
    bus.cmd_offset_i       = '0;
    bus.cmd_wdata_i        = '0;
    bus.rsp_ready_i        = 1'b1;
    bus.lmmi_ready_i       = '0;
    bus.lmmi_rdata_i       = '0;
    bus.lmmi_rdata_valid_i = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
    check("rst_request", 32'(bus.lmmi_request_o), 32'd0);
    check("rst_rsp", {bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_status_o}, 32'd0);
    check("rst_err_cnt", 32'(bus.err_cnt_o), 32'd0);
    check("rst_bcast", {bus.lmmi_wr_rdn_o, bus.lmmi_offset_o, bus.lmmi_wdata_o}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    tick();

    // 1: write ch2, single-cycle request, response two cycles after accept
    bus.lmmi_ready_i = 4'hF;
    exp_q.push_back(rsp_t'{data: 8'h00, status: ST_OK});
    drive_cmd(4'd2, 1'b1, 5'h0A, 8'h5C);
    @(negedge clk);
    check("t1_request", 32'(bus.lmmi_request_o), 32'b0100);
    check("t1_fields", {bus.lmmi_wr_rdn_o, bus.lmmi_offset_o, bus.lmmi_wdata_o},
          {19'd0, 1'b1, 5'h0A, 8'h5C});
    check("t1_rsp_early", 32'(bus.rsp_valid_o), 32'd0);
    @(negedge clk);
    check("t1_req_drop", 32'(bus.lmmi_request_o), 32'd0);
    check("t1_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
    check("t1_bcast_zero", {bus.lmmi_wr_rdn_o, bus.lmmi_offset_o, bus.lmmi_wdata_o}, 32'd0);
    tick();

    // 2: read ch1, 3 stall cycles (other channels ready), rdata 2 cycles after ready
    bus.lmmi_ready_i = 4'b1101;
    exp_q.push_back(rsp_t'{data: 8'hA7, status: ST_OK});
    drive_cmd(4'd1, 1'b0, 5'h13, 8'h3C);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_req_stall", {bus.lmmi_request_o, bus.lmmi_wr_rdn_o, bus.lmmi_offset_o,
            bus.lmmi_wdata_o}, {14'd0, 4'b0010, 1'b0, 5'h13, 8'h3C});
    end
    tick();
    bus.lmmi_ready_i = 4'b0010;
    @(negedge clk);
    check("t2_req_4th", {bus.lmmi_request_o, bus.lmmi_wr_rdn_o, bus.lmmi_offset_o,
          bus.lmmi_wdata_o}, {14'd0, 4'b0010, 1'b0, 5'h13, 8'h3C});
    tick();
    bus.lmmi_ready_i          = 4'h0;
    bus.lmmi_rdata_valid_i    = 4'b1000;
    bus.lmmi_rdata_i[31:24]   = 8'hFF;
    @(negedge clk);
    check("t2_wait_req", 32'(bus.lmmi_request_o), 32'd0);
    check("t2_wait_norsp", 32'(bus.rsp_valid_o), 32'd0);
    tick();
    bus.lmmi_rdata_valid_i    = 4'b0010;
    bus.lmmi_rdata_i[15:8]    = 8'hA7;
    @(negedge clk);
    check("t2_rv_norsp", 32'(bus.rsp_valid_o), 32'd0);
    tick();
    bus.lmmi_rdata_valid_i    = 4'b0000;
    @(negedge clk);
    check("t2_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
    tick();

    // 3: bad channel
    bus.lmmi_ready_i = 4'hF;
    exp_q.push_back(rsp_t'{data: 8'h00, status: ST_BAD_CH});
    drive_cmd(4'd7, 1'b1, 5'h1F, 8'hFF);
    @(negedge clk);
    check("t3_no_request", 32'(bus.lmmi_request_o), 32'd0);
    check("t3_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
    @(negedge clk);
    check("t3_err_cnt", 32'(bus.err_cnt_o), 32'd1);
    tick();

    // 4: response backpressure; same-cycle ready+rdata_valid read; queued next command
    bus.rsp_ready_i          = 1'b0;
    bus.lmmi_rdata_valid_i   = 4'b0001;
    bus.lmmi_rdata_i[7:0]    = 8'h3E;
    exp_q.push_back(rsp_t'{data: 8'h3E, status: ST_OK});
    exp_q.push_back(rsp_t'{data: 8'h00, status: ST_OK});
    drive_cmd(4'd0, 1'b0, 5'h05, 8'h00);
    tick();
    bus.lmmi_rdata_valid_i = 4'b0000;
    bus.cmd_valid_i        = 1'b1;
    bus.cmd_ch_i           = 4'd3;
    bus.cmd_wr_i           = 1'b1;
    bus.cmd_offset_i       = 5'h02;
    bus.cmd_wdata_i        = 8'h99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_stall", {bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_status_o, bus.cmd_ready_o},
            {20'd0, 1'b1, 8'h3E, ST_OK, 1'b0});
    end
    tick();
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    check("t4_hs_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
    @(negedge clk);
    check("t4_next_accept", 32'(bus.cmd_ready_o), 32'd1);
    tick();
    bus.cmd_valid_i = 1'b0;
    @(negedge clk);
    check("t4_next_req", {bus.lmmi_request_o, bus.lmmi_wdata_o}, {20'd0, 4'b1000, 8'h99});
    @(negedge clk);
    check("t4_next_rsp", 32'(bus.rsp_valid_o), 32'd1);
    tick();

    // 5: slave never ready
    bus.lmmi_ready_i = 4'h0;
    cnt  = 0;
    cyc  = 0;
    seen = 1'b0;
`ifdef LMMI_TIMEOUT_EN
    exp_q.push_back(rsp_t'{data: 8'h00, status: ST_TIMEOUT});
    drive_cmd(4'd2, 1'b0, 5'h07, 8'h00);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.rsp_valid_o) seen = 1'b1;
      else if (bus.lmmi_request_o == 4'b0100) cnt++;
    end
    check("t5_req_cycles", 32'(cnt), 32'(TMO));
    check("t5_rsp_cycle", 32'(cyc), 32'(TMO + 1));
    check("t5_req_dropped", 32'(bus.lmmi_request_o), 32'd0);
    tick();
    bus.lmmi_rdata_valid_i = 4'b0100;
    bus.lmmi_rdata_i[23:16] = 8'hA7;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid_o) seen = 1'b1;
    end
    check("t5_late_rvalid", 32'(seen), 32'd0);
    check("t5_err_cnt", 32'(bus.err_cnt_o), 32'd2);
    tick();
    bus.lmmi_rdata_valid_i = 4'b0000;
`else
    drive_cmd(4'd2, 1'b0, 5'h07, 8'h00);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.rsp_valid_o) seen = 1'b1;
      if (bus.lmmi_request_o == 4'b0100) cnt++;
    end
    check("t5_req_held_100", 32'(cnt), 32'd100);
    check("t5_no_rsp", 32'(seen), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5_rst_req", 32'(bus.lmmi_request_o), 32'd0);
    tick();
`endif

    // 6: reset during WAIT_RD, then a clean read
    bus.lmmi_ready_i = 4'hF;
    drive_cmd(4'd3, 1'b0, 5'h04, 8'h00);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("t6_wait_state", {bus.lmmi_request_o, bus.rsp_valid_o}, 32'd0);
    tick();
    @(negedge clk);
    check("t6_rst_outputs", {bus.cmd_ready_o, bus.lmmi_request_o, bus.rsp_valid_o,
          bus.lmmi_wr_rdn_o, bus.lmmi_offset_o, bus.lmmi_wdata_o}, 32'd0);
    check("t6_rst_rsp", {bus.rsp_data_o, bus.rsp_status_o, bus.err_cnt_o}, 32'd0);
    tick();
    rst  = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid_o) seen = 1'b1;
    end
    check("t6_no_rsp", 32'(seen), 32'd0);
    tick();
    exp_q.push_back(rsp_t'{data: 8'hC5, status: ST_OK});
    drive_cmd(4'd3, 1'b0, 5'h04, 8'h00);
    tick();
    bus.lmmi_rdata_valid_i  = 4'b1000;
    bus.lmmi_rdata_i[31:24] = 8'hC5;
    @(negedge clk);
    check("t6_rv_norsp", 32'(bus.rsp_valid_o), 32'd0);
    tick();
    bus.lmmi_rdata_valid_i = 4'b0000;
    @(negedge clk);
    check("t6_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
